// File: rtl/spi_slave_if.sv
// spi_slave_if: serial front end of the SPI slave.
// Deserializes (DATA_W+2)-bit MOSI frames into rx_data/rx_valid.
// Serializes the memory's read data (tx_data/tx_valid) onto MISO during READ_DATA frames.
// Optional build macro: SPI_CMD_CHECK_EN. When it is defined, bit 8 of read frames
// is checked against the routed state, and mismatching frames are dropped.
module spi_slave_if #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ss_n,
    input  logic              mosi,
    output logic              miso,
    output logic [DATA_W+1:0] rx_data,
    output logic              rx_valid,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid
);

    localparam int FRAME_W = DATA_W + 2;
    localparam int CNT_W   = $clog2(FRAME_W + 1);
    localparam int TXC_W   = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(FRAME_W - 1);
    localparam logic [CNT_W-1:0] FRAME_LEN = CNT_W'(FRAME_W);
    localparam logic [TXC_W-1:0] TX_LAST   = TXC_W'(DATA_W);
    localparam logic [TXC_W-1:0] TX_PENULT = TXC_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CHK_CMD   = 3'd1,
        WRITE     = 3'd2,
        READ_ADD  = 3'd3,
        READ_DATA = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [FRAME_W-1:0] shift_q, shift_d;
    logic [FRAME_W-1:0] rx_data_q, rx_data_d;
    logic               rx_valid_q, rx_valid_d;
    logic               rd_addr_done_q, rd_addr_done_d;
    logic               tx_armed_q, tx_armed_d;   // READ_DATA frame completed, waiting for tx_valid
    logic [DATA_W-1:0]  tx_sh_q, tx_sh_d;
    logic [TXC_W-1:0]   tx_cnt_q, tx_cnt_d;       // 0 = idle, 1..DATA_W = bit on miso
    logic               miso_q, miso_d;

    logic [FRAME_W-1:0] frame_word;
    logic               cmd_ok;

    // Word as it will look once the current mosi bit is shifted in, plus the bit-8 check.
    always_comb begin
        frame_word = {shift_q[FRAME_W-2:0], mosi};
`ifdef SPI_CMD_CHECK_EN
        if (state_q == READ_ADD)
            cmd_ok = ~shift_q[FRAME_W-3];
        else if (state_q == READ_DATA)
            cmd_ok = shift_q[FRAME_W-3];
        else
            cmd_ok = 1'b1;
`else
        cmd_ok = 1'b1;
`endif
    end

    // Next-state logic: frame FSM, receive shifter, transmit shifter and abort handling.
    always_comb begin
        state_d        = state_q;
        bit_cnt_d      = bit_cnt_q;
        shift_d        = shift_q;
        rx_data_d      = rx_data_q;
        rx_valid_d     = 1'b0;
        rd_addr_done_d = rd_addr_done_q;
        tx_armed_d     = tx_armed_q;
        tx_sh_d        = tx_sh_q;
        tx_cnt_d       = tx_cnt_q;
        miso_d         = miso_q;

        // Transmit path: runs only after a load inside a completed READ_DATA frame.
        if (tx_cnt_q != '0) begin
            if (tx_cnt_q == TX_LAST) begin
                miso_d   = 1'b0;
                tx_cnt_d = '0;
            end else begin
                miso_d   = tx_sh_q[DATA_W-1];
                tx_sh_d  = tx_sh_q << 1;
                tx_cnt_d = tx_cnt_q + 1'b1;
                if (tx_cnt_q == TX_PENULT)
                    rd_addr_done_d = 1'b0;   // last data bit is going out now
            end
        end else if (state_q == READ_DATA && tx_armed_q && tx_valid) begin
            miso_d     = tx_data[DATA_W-1];
            tx_sh_d    = tx_data << 1;
            tx_cnt_d   = TXC_W'(1);
            tx_armed_d = 1'b0;
        end

        if (state_q != IDLE && ss_n) begin
            // Frame abort: drop partial bits and cancel any transmit in flight.
            state_d        = IDLE;
            bit_cnt_d      = '0;
            shift_d        = '0;
            miso_d         = 1'b0;
            tx_cnt_d       = '0;
            tx_sh_d        = '0;
            tx_armed_d     = 1'b0;
            rd_addr_done_d = rd_addr_done_q;
        end else begin
            case (state_q)
                IDLE: begin
                    bit_cnt_d = '0;
                    if (!ss_n)
                        state_d = CHK_CMD;
                end
                CHK_CMD: begin
                    shift_d   = {{(FRAME_W-1){1'b0}}, mosi};
                    bit_cnt_d = CNT_W'(1);
                    if (!mosi)
                        state_d = WRITE;
                    else if (rd_addr_done_q)
                        state_d = READ_DATA;
                    else
                        state_d = READ_ADD;
                end
                WRITE, READ_ADD, READ_DATA: begin
                    if (bit_cnt_q < FRAME_LEN) begin
                        shift_d   = frame_word;
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        if (bit_cnt_q == LAST_BIT && cmd_ok) begin
                            rx_data_d  = frame_word;
                            rx_valid_d = 1'b1;
                            if (state_q == READ_ADD)
                                rd_addr_done_d = 1'b1;
                            if (state_q == READ_DATA)
                                tx_armed_d = 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            bit_cnt_q      <= '0;
            shift_q        <= '0;
            rx_data_q      <= '0;
            rx_valid_q     <= 1'b0;
            rd_addr_done_q <= 1'b0;
            tx_armed_q     <= 1'b0;
            tx_sh_q        <= '0;
            tx_cnt_q       <= '0;
            miso_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            bit_cnt_q      <= bit_cnt_d;
            shift_q        <= shift_d;
            rx_data_q      <= rx_data_d;
            rx_valid_q     <= rx_valid_d;
            rd_addr_done_q <= rd_addr_done_d;
            tx_armed_q     <= tx_armed_d;
            tx_sh_q        <= tx_sh_d;
            tx_cnt_q       <= tx_cnt_d;
            miso_q         <= miso_d;
        end
    end

    assign miso     = miso_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;

endmodule

// File: tb/tb_spi_slave_if.sv
// Self-checking bench for spi_slave_if: scoreboard of expected rx words and MISO bits.
module tb_spi_slave_if;

    logic       clk = 1'b0;
    logic       rst;
    logic       ss_n;
    logic       mosi;
    logic       miso;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;

    int         checks = 0;
    int         errors = 0;
    int         rx_cnt = 0;
    logic [9:0] rx_q[$];
    logic       mq[$];
    logic       miso_or;
    int         c0;

    spi_slave_if #(.DATA_W(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .ss_n     (ss_n),
        .mosi     (mosi),
        .miso     (miso),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    // Receive-side monitor: every rx_valid pulse must match the next expected word.
    always @(negedge clk) begin
        if (!rst && rx_valid) begin
            rx_cnt++;
            if (rx_q.size() == 0)
                check_eq("rx_unexpected", {22'd0, rx_data}, 32'hFFFF_FFFF);
            else
                check_eq("rx_data", {22'd0, rx_data}, {22'd0, rx_q.pop_front()});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(negedge clk);
        miso_or = miso_or | miso;
    endtask

    // Drives E0 plus ten bits, returns just after E10 with ss_n still low.
    task automatic send_frame(input logic [9:0] w, input bit exp_rx, input bit tx_pulse);
        if (exp_rx) rx_q.push_back(w);
        tick; ss_n = 1'b0; mosi = 1'b0;
        for (int i = 9; i >= 0; i--) begin
            tick;
            mosi     = w[i];
            tx_valid = tx_pulse && (i == 4);
        end
        tick;
        tx_valid = 1'b0;
    endtask

    task automatic end_frame;
        ss_n = 1'b1; mosi = 1'b0;
        tick;
    endtask

    // Memory answers one cycle after rx_valid; then samples n MISO bits.
    task automatic read_data(input logic [7:0] d, input int n);
        tick;
        tx_valid = 1'b1; tx_data = d;
        for (int b = 7; b >= 0; b--) mq.push_back(d[b]);
        tick;
        tx_valid = 1'b0;
        for (int k = 0; k < n; k++) begin
            if (k > 0) tick;
            check_eq("miso_bit", {31'd0, miso}, {31'd0, mq.pop_front()});
        end
    endtask

    initial begin
        rst = 1'b1; ss_n = 1'b0; mosi = 1'b1; tx_valid = 1'b0; tx_data = 8'h00; miso_or = 1'b0;
        repeat (3) tick;
        check_eq("rst_miso", {31'd0, miso}, 0);
        check_eq("rst_rx_valid", {31'd0, rx_valid}, 0);
        check_eq("rst_rx_data", {22'd0, rx_data}, 0);
        check_eq("rst_state", {29'd0, dut.state_q}, 0);
        check_eq("rst_bit_cnt", {28'd0, dut.bit_cnt_q}, 0);
        check_eq("rst_rd_addr_done", {31'd0, dut.rd_addr_done_q}, 0);
        ss_n = 1'b1; rst = 1'b0; mosi = 1'b0;
        tick;

        // Write address then write data; miso must stay low.
        miso_or = 1'b0; c0 = rx_cnt;
        send_frame(10'h03C, 1, 0); end_frame;
        check_eq("wr_addr_pulses", rx_cnt - c0, 1);
        send_frame(10'h1A5, 1, 0); end_frame;
        check_eq("wr_data_pulses", rx_cnt - c0, 2);
        check_eq("wr_miso_quiet", {31'd0, miso_or}, 0);

        // Read address then read data with the memory returning 0xA5.
        send_frame(10'h23C, 1, 0); end_frame;
        check_eq("rd_addr_done_set", {31'd0, dut.rd_addr_done_q}, 1);
        send_frame(10'h300, 1, 0);
        read_data(8'hA5, 8);
        tick;
        check_eq("rd_miso_after", {31'd0, miso}, 0);
        check_eq("rd_addr_done_clr", {31'd0, dut.rd_addr_done_q}, 0);
        end_frame;

        // Abort after five bits of a write frame, then a clean frame.
        c0 = rx_cnt;
        tick; ss_n = 1'b0; mosi = 1'b0;
        for (int i = 9; i >= 5; i--) begin
            tick;
            mosi = ((10'h0A5 >> i) & 10'h1) != 0;
        end
        tick;
        ss_n = 1'b1;
        tick;
        check_eq("abort_state", {29'd0, dut.state_q}, 0);
        check_eq("abort_bit_cnt", {28'd0, dut.bit_cnt_q}, 0);
        tick;
        check_eq("abort_no_rx", rx_cnt - c0, 0);
        send_frame(10'h011, 1, 0); end_frame;
        check_eq("post_abort_rx", rx_cnt - c0, 1);

        // Reset in the middle of a transmit.
        send_frame(10'h23C, 1, 0); end_frame;
        send_frame(10'h300, 1, 0);
        read_data(8'hA5, 3);
        rst = 1'b1;
        tick;
        check_eq("mid_rst_miso", {31'd0, miso}, 0);
        check_eq("mid_rst_state", {29'd0, dut.state_q}, 0);
        check_eq("mid_rst_rd_addr_done", {31'd0, dut.rd_addr_done_q}, 0);
        for (int k = 0; k < 3; k++) begin
            mosi = k[0]; tx_valid = 1'b1; tx_data = 8'hFF;
            tick;
            check_eq("hold_rst_miso", {31'd0, miso}, 0);
            check_eq("hold_rst_rx_valid", {31'd0, rx_valid}, 0);
            check_eq("hold_rst_rx_data", {22'd0, rx_data}, 0);
        end
        tx_valid = 1'b0; rst = 1'b0; ss_n = 1'b1; mosi = 1'b0;
        tick;
        mq.delete();

        // Two read-address-class frames back to back: second goes to READ_DATA.
        c0 = rx_cnt;
        send_frame(10'h23C, 1, 0); end_frame;
`ifdef SPI_CMD_CHECK_EN
        send_frame(10'h255, 0, 0);
        check_eq("b2b_state", {29'd0, dut.state_q}, 4);
        tick;
        check_eq("b2b_pulses", rx_cnt - c0, 1);
`else
        send_frame(10'h255, 1, 0);
        check_eq("b2b_state", {29'd0, dut.state_q}, 4);
        tick;
        check_eq("b2b_pulses", rx_cnt - c0, 2);
`endif
        end_frame;
        rst = 1'b1; tick; rst = 1'b0; tick;

        // tx_valid pulsed during and after a WRITE frame is ignored.
        miso_or = 1'b0;
        send_frame(10'h0F0, 1, 1);
        tx_valid = 1'b1; tx_data = 8'hFF;
        tick; tick;
        tx_valid = 1'b0;
        repeat (9) tick;
        end_frame;
        check_eq("wr_txv_miso_quiet", {31'd0, miso_or}, 0);

        repeat (3) tick;
        check_eq("sb_rx_empty", rx_q.size(), 0);
        check_eq("sb_miso_empty", mq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
